// File: rtl/redirect_ctrl.sv
// Branch-resolution / pipeline-redirect controller.
// Compares each resolved control-flow outcome from MEM against the front-end
// prediction. A mismatch produces a registered PC redirect plus a FLUSH
// pulse, followed by a squash window in which wrong-path resolutions are
// dropped. Every accepted resolution also drives the predictor update port
// and the saturating statistics counters.
module redirect_ctrl #(
  parameter int unsigned FALLTHROUGH_OFFSET = 8,
  parameter int unsigned SQUASH_CYCLES      = 3,
  parameter int unsigned CNT_W              = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL_IN,
  input  logic             Branch_valid_IN,
  input  logic [31:0]      Branch_PC_IN,
  input  logic             Branch_taken_IN,
  input  logic [31:0]      Branch_target_IN,
  input  logic             Predicted_taken_IN,
  input  logic [31:0]      Predicted_target_IN,
  output logic             Request_Alt_PC_OUT,
  output logic [31:0]      Alt_PC_OUT,
  output logic             FLUSH_OUT,
  output logic             Update_valid_OUT,
  output logic [31:0]      Update_PC_OUT,
  output logic             Update_taken_OUT,
  output logic [31:0]      Update_target_OUT,
  output logic [CNT_W-1:0] Branch_count_OUT,
  output logic [CNT_W-1:0] Mispredict_count_OUT
);

  // Squash counter only needs to hold SQUASH_CYCLES-1.
  localparam int unsigned SqW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
  localparam logic [SqW-1:0] SqLoad = SqW'(SQUASH_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRedirect,
    StSquash
  } state_e;

  state_e           r_state;
  logic [SqW-1:0]   r_sq_cnt;
  logic             r_req;
  logic             r_flush;
  logic [31:0]      r_alt_pc;
  logic             r_upd_valid;
  logic [31:0]      r_upd_pc;
  logic             r_upd_taken;
  logic [31:0]      r_upd_target;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  logic        w_accept;
  logic        w_mispredict;
  logic [31:0] w_correct_pc;

  // Resolutions are only taken in IDLE; REDIRECT and SQUASH see wrong-path work.
  always_comb begin
    w_accept     = (r_state == StIdle) & Branch_valid_IN & ~STALL_IN;
    w_mispredict = (Branch_taken_IN != Predicted_taken_IN) |
                   (Branch_taken_IN & Predicted_taken_IN &
                    (Branch_target_IN != Predicted_target_IN));
    // Fall-through skips the delay slot; 32-bit wrap is intentional.
    w_correct_pc = Branch_taken_IN ? Branch_target_IN
                                   : Branch_PC_IN + 32'(FALLTHROUGH_OFFSET);
  end

  // Redirect FSM, update port and statistics counters, all registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= StIdle;
      r_sq_cnt     <= '0;
      r_req        <= 1'b0;
      r_flush      <= 1'b0;
      r_alt_pc     <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_pc     <= '0;
      r_upd_taken  <= 1'b0;
      r_upd_target <= '0;
      r_br_cnt     <= '0;
      r_mp_cnt     <= '0;
    end else begin
      // Update strobe is a single-cycle pulse per accepted resolution.
      r_upd_valid <= w_accept;
      if (w_accept) begin
        r_upd_pc     <= Branch_PC_IN;
        r_upd_taken  <= Branch_taken_IN;
        r_upd_target <= Branch_target_IN;
        if (!(&r_br_cnt)) r_br_cnt <= r_br_cnt + CNT_W'(1);
      end

      unique case (r_state)
        StIdle: begin
          if (w_accept && w_mispredict) begin
            r_alt_pc <= w_correct_pc;
            r_req    <= 1'b1;
            r_flush  <= 1'b1;
            r_state  <= StRedirect;
            if (!(&r_mp_cnt)) r_mp_cnt <= r_mp_cnt + CNT_W'(1);
          end
        end
        StRedirect: begin
          // A stalled IF cannot consume the redirect, so hold it.
          if (!STALL_IN) begin
            r_req    <= 1'b0;
            r_flush  <= 1'b0;
            r_sq_cnt <= SqLoad;
            r_state  <= (SQUASH_CYCLES == 1) ? StIdle : StSquash;
          end
        end
        StSquash: begin
          if (!STALL_IN) begin
            if (r_sq_cnt == '0) r_state <= StIdle;
            else                r_sq_cnt <= r_sq_cnt - SqW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign Request_Alt_PC_OUT   = r_req;
  assign FLUSH_OUT            = r_flush;
  assign Alt_PC_OUT           = r_alt_pc;
  assign Update_valid_OUT     = r_upd_valid;
  assign Update_PC_OUT        = r_upd_pc;
  assign Update_taken_OUT     = r_upd_taken;
  assign Update_target_OUT    = r_upd_target;
  assign Branch_count_OUT     = r_br_cnt;
  assign Mispredict_count_OUT = r_mp_cnt;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: stimulus pushes expected update and
// redirect events into queues; a negedge monitor pops and compares them
// whenever the DUT presents Update_valid_OUT or Request_Alt_PC_OUT.
module tb_redirect_ctrl;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          STALL_IN = 1'b0;
  logic          Branch_valid_IN = 1'b0;
  logic [31:0]   Branch_PC_IN = '0;
  logic          Branch_taken_IN = 1'b0;
  logic [31:0]   Branch_target_IN = '0;
  logic          Predicted_taken_IN = 1'b0;
  logic [31:0]   Predicted_target_IN = '0;
  logic          Request_Alt_PC_OUT;
  logic [31:0]   Alt_PC_OUT;
  logic          FLUSH_OUT;
  logic          Update_valid_OUT;
  logic [31:0]   Update_PC_OUT;
  logic          Update_taken_OUT;
  logic [31:0]   Update_target_OUT;
  logic [CW-1:0] Branch_count_OUT;
  logic [CW-1:0] Mispredict_count_OUT;

  redirect_ctrl #(
    .FALLTHROUGH_OFFSET(8),
    .SQUASH_CYCLES(3),
    .CNT_W(CW)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .STALL_IN(STALL_IN),
    .Branch_valid_IN(Branch_valid_IN),
    .Branch_PC_IN(Branch_PC_IN),
    .Branch_taken_IN(Branch_taken_IN),
    .Branch_target_IN(Branch_target_IN),
    .Predicted_taken_IN(Predicted_taken_IN),
    .Predicted_target_IN(Predicted_target_IN),
    .Request_Alt_PC_OUT(Request_Alt_PC_OUT),
    .Alt_PC_OUT(Alt_PC_OUT),
    .FLUSH_OUT(FLUSH_OUT),
    .Update_valid_OUT(Update_valid_OUT),
    .Update_PC_OUT(Update_PC_OUT),
    .Update_taken_OUT(Update_taken_OUT),
    .Update_target_OUT(Update_target_OUT),
    .Branch_count_OUT(Branch_count_OUT),
    .Mispredict_count_OUT(Mispredict_count_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]   pc;
    logic          tk;
    logic [31:0]   tgt;
    logic [CW-1:0] bc;
  } upd_t;

  typedef struct packed {
    logic [31:0]   alt;
    logic [CW-1:0] mc;
  } rd_t;

  upd_t          upd_q[$];
  rd_t           rd_q[$];
  int            total = 0;
  int            bad = 0;
  logic          mon_en = 1'b0;
  logic [CW-1:0] exp_bc = '0;
  logic [CW-1:0] exp_mc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge CLK) begin
    if (mon_en) begin
      upd_t u;
      rd_t  r;
      chk("flush_eq_req", {31'b0, FLUSH_OUT}, {31'b0, Request_Alt_PC_OUT});
      if (Update_valid_OUT === 1'b1) begin
        if (upd_q.size() == 0) chk("unexpected_update", 32'd1, 32'd0);
        else begin
          u = upd_q.pop_front();
          chk("upd_pc", Update_PC_OUT, u.pc);
          chk("upd_taken", {31'b0, Update_taken_OUT}, {31'b0, u.tk});
          chk("upd_target", Update_target_OUT, u.tgt);
          chk("branch_count", 32'(Branch_count_OUT), 32'(u.bc));
        end
      end
      if (Request_Alt_PC_OUT === 1'b1) begin
        if (rd_q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
        else begin
          r = rd_q.pop_front();
          chk("alt_pc", Alt_PC_OUT, r.alt);
          chk("mispredict_count", 32'(Mispredict_count_OUT), 32'(r.mc));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      Branch_valid_IN = 1'b0;
      STALL_IN        = 1'b0;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      Branch_valid_IN = 1'b0;
      STALL_IN        = 1'b1;
    end
  endtask

  // One resolution cycle; acc/mis/alt are the hand-computed expectations,
  // nst is how many stalled cycles will hold the redirect.
  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptgt, input logic acc,
                    input logic mis, input logic [31:0] alt, input int nst);
    upd_t u;
    rd_t  r;
    @(posedge CLK); #1;
    STALL_IN            = 1'b0;
    Branch_valid_IN     = 1'b1;
    Branch_PC_IN        = pc;
    Branch_taken_IN     = tk;
    Branch_target_IN    = tgt;
    Predicted_taken_IN  = ptk;
    Predicted_target_IN = ptgt;
    if (acc) begin
      if (exp_bc != '1) exp_bc = exp_bc + 1'b1;
      u.pc = pc; u.tk = tk; u.tgt = tgt; u.bc = exp_bc;
      upd_q.push_back(u);
      if (mis) begin
        if (exp_mc != '1) exp_mc = exp_mc + 1'b1;
        r.alt = alt; r.mc = exp_mc;
        repeat (1 + nst) rd_q.push_back(r);
      end
    end
  endtask

  initial begin
    // Reset state
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", {31'b0, Request_Alt_PC_OUT}, 32'd0);
    chk("rst_flush", {31'b0, FLUSH_OUT}, 32'd0);
    chk("rst_upd_valid", {31'b0, Update_valid_OUT}, 32'd0);
    chk("rst_alt_pc", Alt_PC_OUT, 32'd0);
    chk("rst_upd_pc", Update_PC_OUT, 32'd0);
    chk("rst_upd_target", Update_target_OUT, 32'd0);
    chk("rst_bc", 32'(Branch_count_OUT), 32'd0);
    chk("rst_mc", 32'(Mispredict_count_OUT), 32'd0);
    RESET  = 1'b0;
    mon_en = 1'b1;

    // Correct not-taken prediction
    br(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 0);
    idle(2);
    chk("nt_bc", 32'(Branch_count_OUT), 32'd1);
    chk("nt_upd_pulse_done", {31'b0, Update_valid_OUT}, 32'd0);

    // Direction mispredict, then three wrong-path resolutions
    br(32'h0040_0040, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0100, 0);
    repeat (3) br(32'h0040_0044, 1'b1, 32'h0000_9000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    idle(2);
    chk("squash_bc", 32'(Branch_count_OUT), 32'd2);
    chk("squash_mc", 32'(Mispredict_count_OUT), 32'd1);
    chk("alt_pc_hold", Alt_PC_OUT, 32'h0040_0100);

    // Predicted taken, actually not taken: fall-through, then wrap
    br(32'h0040_0020, 1'b0, 32'h0040_0800, 1'b1, 32'h0040_0800, 1'b1, 1'b1,
       32'h0040_0028, 0);
    idle(4);
    br(32'hFFFF_FFFC, 1'b0, 32'h0040_0800, 1'b1, 32'h0040_0800, 1'b1, 1'b1,
       32'h0000_0004, 0);
    idle(4);

    // Target mispredict, then matching targets
    br(32'h0040_0030, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_1000, 1'b1, 1'b1,
       32'h0000_2000, 0);
    idle(4);
    br(32'h0040_0034, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 0);
    idle(2);
    chk("match_mc", 32'(Mispredict_count_OUT), 32'd4);

    // Stall holds the redirect for 3 cycles; squash window follows the stall
    br(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0200, 2);
    stall(2);
    repeat (3) br(32'h0040_0054, 1'b1, 32'h0000_7000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    idle(4);
    chk("stall_bc", 32'(Branch_count_OUT), 32'd7);
    chk("stall_mc", 32'(Mispredict_count_OUT), 32'd5);

    // Reset mid-squash, then a mispredict right after release
    br(32'h0040_0060, 1'b1, 32'h0040_0300, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0300, 0);
    idle(1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_rst_req", {31'b0, Request_Alt_PC_OUT}, 32'd0);
    chk("mid_rst_flush", {31'b0, FLUSH_OUT}, 32'd0);
    chk("mid_rst_upd", {31'b0, Update_valid_OUT}, 32'd0);
    chk("mid_rst_alt", Alt_PC_OUT, 32'd0);
    chk("mid_rst_bc", 32'(Branch_count_OUT), 32'd0);
    chk("mid_rst_mc", 32'(Mispredict_count_OUT), 32'd0);
    RESET  = 1'b0;
    exp_bc = '0;
    exp_mc = '0;
    br(32'h0040_0070, 1'b0, 32'h0040_0900, 1'b1, 32'h0040_0900, 1'b1, 1'b1,
       32'h0040_0078, 0);
    idle(5);
    chk("post_rst_mc", 32'(Mispredict_count_OUT), 32'd1);

    // Saturation: 17 more accepted branches
    for (int i = 0; i < 17; i++)
      br(32'h0000_0100 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 0);
    idle(2);
    chk("sat_bc", 32'(Branch_count_OUT), 32'hF);
    chk("sat_mc", 32'(Mispredict_count_OUT), 32'd1);
    chk("upd_q_drained", 32'(upd_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
